// File: rtl/bwt_arb_pkg.sv
// bwt_arb_pkg: shared widths, tag layout, FSM encoding and request record for the occ-request arbiter
package bwt_arb_pkg;
    localparam int ADDR_W = 42;
    localparam int TAG_W = 9;
    localparam int KL_BIT = 0;
    localparam int SRC_BIT = TAG_W + 1;
    localparam logic SRC_FWD = 1'b0;
    localparam logic SRC_BWD = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} arb_state_e;
    typedef struct packed {
        logic [ADDR_W-1:0] k;
        logic [ADDR_W-1:0] l;
        logic [TAG_W-1:0] rn;
    } req_t;
    function automatic logic [TAG_W+1:0] mk_tag(input logic src, input logic [TAG_W-1:0] rn, input logic kl);
        return {src, rn, kl};
    endfunction
endpackage

// File: rtl/bwt_occ_req_arbiter_fifo.sv
// bwt_req_fifo: sync request FIFO exposing head, head+1 and count; a push that finds it full without a pop is dropped
module bwt_req_fifo
    import bwt_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_t                     din,
    input  logic                     pop,
    output req_t                     head,
    output req_t                     head_next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    req_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic do_push, do_pop;
    assign do_pop = pop && count != '0;
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign drop = rst && push && !do_push;
    assign rd_nxt = rd_ptr + AW'(1);
    assign head = mem[rd_ptr];
    assign head_next = mem[rd_nxt];
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_nxt;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/bwt_occ_req_arbiter.sv
// bwt_occ_req_arbiter: round-robin share of the occurrence-memory port, two beats (k then l) per request
module bwt_occ_req_arbiter
    import bwt_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SLACK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_addr_k,
    input  logic [ADDR_W-1:0] f_addr_l,
    input  logic [TAG_W-1:0]  f_read_num,
    input  logic              b_req_valid,
    input  logic [ADDR_W-1:0] b_addr_k,
    input  logic [ADDR_W-1:0] b_addr_l,
    input  logic [TAG_W-1:0]  b_read_num,
    output logic              f_stall,
    output logic              b_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [TAG_W+1:0]  mem_req_tag,
    output logic              ovf_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    arb_state_e state, state_nxt;
    logic gnt, gnt_nxt, last, last_nxt, pick, valid_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [TAG_W+1:0] tag_nxt;
    req_t f_head, f_head2, b_head, b_head2, nxt_req, cur;
    logic [CW-1:0] f_cnt, b_cnt;
    logic f_drop, b_drop, f_pop, b_pop, fire_l, f_left, b_left;

    bwt_req_fifo #(.DEPTH(DEPTH)) u_f_fifo (
        .clk(clk), .rst(rst), .push(f_req_valid), .din({f_addr_k, f_addr_l, f_read_num}),
        .pop(f_pop), .head(f_head), .head_next(f_head2), .count(f_cnt), .drop(f_drop)
    );
    bwt_req_fifo #(.DEPTH(DEPTH)) u_b_fifo (
        .clk(clk), .rst(rst), .push(b_req_valid), .din({b_addr_k, b_addr_l, b_read_num}),
        .pop(b_pop), .head(b_head), .head_next(b_head2), .count(b_cnt), .drop(b_drop)
    );

    assign f_stall = rst && f_cnt >= CW'(DEPTH - SLACK);
    assign b_stall = rst && b_cnt >= CW'(DEPTH - SLACK);
    assign fire_l = state == ISSUE_L && mem_req_ready;
    assign f_pop = fire_l && gnt == SRC_FWD;
    assign b_pop = fire_l && gnt == SRC_BWD;
    // occupancy as it will be once the finishing request leaves, so re-grant needs no bubble
    assign f_left = f_cnt > CW'(f_pop);
    assign b_left = b_cnt > CW'(b_pop);
    assign last_nxt = fire_l ? gnt : last;
    assign pick = (f_left && b_left) ? ~last_nxt : b_left;
    assign nxt_req = pick ? (b_pop ? b_head2 : b_head) : (f_pop ? f_head2 : f_head);
    assign cur = gnt ? b_head : f_head;

    always_comb begin
        state_nxt = state;
        gnt_nxt = gnt;
        valid_nxt = mem_req_valid;
        addr_nxt = mem_req_addr;
        tag_nxt = mem_req_tag;
        if ((state == IDLE || fire_l) && (f_left || b_left)) begin
            state_nxt = ISSUE_K;
            gnt_nxt = pick;
            valid_nxt = 1'b1;
            addr_nxt = nxt_req.k;
            tag_nxt = mk_tag(pick, nxt_req.rn, 1'b0);
        end else if (fire_l || !(state inside {ISSUE_K, ISSUE_L})) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
        end else if (state == ISSUE_K && mem_req_ready) begin
            state_nxt = ISSUE_L;
            addr_nxt = cur.l;
            tag_nxt = mk_tag(gnt, cur.rn, 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            gnt <= SRC_FWD;
            last <= SRC_BWD;
            mem_req_valid <= 1'b0;
            mem_req_addr <= '0;
            mem_req_tag <= '0;
            ovf_err <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt <= gnt_nxt;
            last <= last_nxt;
            mem_req_valid <= valid_nxt;
            mem_req_addr <= addr_nxt;
            mem_req_tag <= tag_nxt;
            ovf_err <= ovf_err | f_drop | b_drop;
        end
    end
endmodule

// File: tb/tb_bwt_occ_req_arbiter.sv
// tb_bwt_occ_req_arbiter: directed vector table, hand sequences and a queue-model random run
module tb_bwt_occ_req_arbiter;
    import bwt_arb_pkg::*;
    logic clk = 0, rst = 0;
    logic f_req_valid = 0, b_req_valid = 0, mem_req_ready = 1;
    logic [ADDR_W-1:0] f_addr_k = 0, f_addr_l = 0, b_addr_k = 0, b_addr_l = 0;
    logic [TAG_W-1:0] f_read_num = 0, b_read_num = 0;
    logic f_stall, b_stall, mem_req_valid, ovf_err;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [TAG_W+1:0] mem_req_tag;
    int total = 0, bad = 0;

    bwt_occ_req_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_addr_k(f_addr_k), .f_addr_l(f_addr_l), .f_read_num(f_read_num),
        .b_req_valid(b_req_valid), .b_addr_k(b_addr_k), .b_addr_l(b_addr_l), .b_read_num(b_read_num),
        .f_stall(f_stall), .b_stall(b_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, fv, bv, rdy;
        logic [ADDR_W-1:0] fk, fl, bk, bl;
        logic [TAG_W-1:0] frn, brn;
        logic ev;
        logic [ADDR_W-1:0] ea;
        logic [TAG_W+1:0] et;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] k, l;
        logic [TAG_W-1:0] rn;
    } ent_t;

    vec_t v[$];
    ent_t fq[$], bq[$];

    function automatic vec_t mk(input logic r, input logic fv, input logic [ADDR_W-1:0] fk, fl,
                                input logic [TAG_W-1:0] frn, input logic bv, input logic [ADDR_W-1:0] bk, bl,
                                input logic [TAG_W-1:0] brn, input logic rdy, input logic ev,
                                input logic [ADDR_W-1:0] ea, input logic [TAG_W+1:0] et);
        vec_t x;
        x.r = r; x.fv = fv; x.fk = fk; x.fl = fl; x.frn = frn;
        x.bv = bv; x.bk = bk; x.bl = bl; x.brn = brn; x.rdy = rdy;
        x.ev = ev; x.ea = ea; x.et = et;
        return x;
    endfunction

    function automatic logic [TAG_W+1:0] tg(input int src, input int rn, input int kl);
        return (TAG_W+2)'((src << (TAG_W + 1)) | (rn << 1) | kl);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 0; f_req_valid = 0; b_req_valid = 0;
        step();
        rst = 1;
    endtask

    initial begin
        logic pend, pend_src, pv, pr, src, kl, cur_src;
        logic [ADDR_W-1:0] pa;
        logic [TAG_W+1:0] pt;
        ent_t e;
        int n, pushed, burst;
        v.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(1, 1,'h100,'h1FF,5, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h100,tg(0,5,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h1FF,tg(0,5,1)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(1, 1,'h200,'h201,1, 1,'h300,'h301,2, 1, 0,0,0));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h200,tg(0,1,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h201,tg(0,1,1)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h300,tg(1,2,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h301,tg(1,2,1)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(1, 1,'h100,'h1FF,5, 0,0,0,0, 1, 0,0,0));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h100,tg(0,5,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 1,'h100,tg(0,5,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 1,'h100,tg(0,5,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0, 1,'h100,tg(0,5,0)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 1,'h1FF,tg(0,5,1)));
        v.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1, 0,0,0));
        foreach (v[i]) begin
            rst = v[i].r; mem_req_ready = v[i].rdy;
            f_req_valid = v[i].fv; f_addr_k = v[i].fk; f_addr_l = v[i].fl; f_read_num = v[i].frn;
            b_req_valid = v[i].bv; b_addr_k = v[i].bk; b_addr_l = v[i].bl; b_read_num = v[i].brn;
            step();
            chk($sformatf("row%0d_valid", i), mem_req_valid, v[i].ev);
            if (v[i].ev || !v[i].r) begin
                chk($sformatf("row%0d_addr", i), mem_req_addr, v[i].ea);
                chk($sformatf("row%0d_tag", i), mem_req_tag, v[i].et);
            end
            chk($sformatf("row%0d_stall", i), {f_stall, b_stall}, 0);
            chk($sformatf("row%0d_ovf", i), ovf_err, 0);
        end

        // overflow: ready held low, nine pushes into an eight-deep FIFO
        do_reset();
        mem_req_ready = 0;
        for (int i = 0; i < 9; i++) begin
            f_req_valid = 1; f_addr_k = ADDR_W'('h1000 + i); f_addr_l = ADDR_W'('h2000 + i); f_read_num = TAG_W'(10 + i);
            step();
            if (i == 2) chk("ovf_stall_after3", f_stall, 0);
            if (i == 3) chk("ovf_stall_after4", f_stall, 1);
            if (i == 7) chk("ovf_err_after8", ovf_err, 0);
            if (i == 8) chk("ovf_err_after9", ovf_err, 1);
        end
        f_req_valid = 0; mem_req_ready = 1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (mem_req_valid) begin
                if (n < 16) begin
                    chk($sformatf("ovf_beat%0d_addr", n), mem_req_addr, (n % 2 ? 'h2000 : 'h1000) + n / 2);
                    chk($sformatf("ovf_beat%0d_tag", n), mem_req_tag, tg(0, 10 + n / 2, n % 2));
                end
                n++;
            end
            step();
        end
        chk("ovf_beat_count", n, 16);
        chk("ovf_sticky", ovf_err, 1);
        chk("ovf_stall_drained", f_stall, 0);

        // reset while the l beat is pending
        do_reset();
        chk("rst_clears_ovf", ovf_err, 0);
        mem_req_ready = 0;
        f_req_valid = 1; f_addr_k = 'h500; f_addr_l = 'h501; f_read_num = 7;
        for (int i = 0; i < 4; i++) begin
            b_req_valid = 1; b_addr_k = ADDR_W'('h600 + i); b_addr_l = ADDR_W'('h680 + i); b_read_num = TAG_W'(20 + i);
            step();
            f_req_valid = 0;
        end
        b_req_valid = 0;
        chk("rst_pre_bstall", b_stall, 1);
        chk("rst_pre_kaddr", mem_req_addr, 'h500);
        mem_req_ready = 1;
        step();
        chk("rst_pre_laddr", mem_req_addr, 'h501);
        chk("rst_pre_ltag", mem_req_tag, tg(0, 7, 1));
        rst = 0; mem_req_ready = 0;
        #1;
        chk("rst_during_stall", {f_stall, b_stall}, 0);
        step();
        chk("rst_valid_drop", mem_req_valid, 0);
        chk("rst_after_stall", {f_stall, b_stall}, 0);
        rst = 1; mem_req_ready = 1;
        step();
        f_req_valid = 1; f_addr_k = 'h700; f_addr_l = 'h701; f_read_num = 3;
        step();
        f_req_valid = 0;
        chk("rst_new_t1", mem_req_valid, 0);
        step();
        chk("rst_new_t2_valid", mem_req_valid, 1);
        chk("rst_new_t2_addr", mem_req_addr, 'h700);
        chk("rst_new_t2_tag", mem_req_tag, tg(0, 3, 0));
        step();
        chk("rst_new_l_addr", mem_req_addr, 'h701);
        step();
        chk("rst_flushed_bwd", mem_req_valid, 0);

        // random bursts against a per-source queue model
        do_reset();
        pend = 0; pend_src = 0; pv = 0; pr = 0; pa = 0; pt = 0;
        pushed = 0; burst = 0; cur_src = 1;
        for (int c = 0; c < 3000 && (pushed < 40 || fq.size() != 0 || bq.size() != 0); c++) begin
            chk("rnd_f_stall", f_stall, fq.size() >= 4);
            chk("rnd_b_stall", b_stall, bq.size() >= 4);
            if (pv && !pr) begin
                chk("rnd_hold_valid", mem_req_valid, 1);
                chk("rnd_hold_addr", mem_req_addr, pa);
                chk("rnd_hold_tag", mem_req_tag, pt);
            end
            mem_req_ready = $urandom_range(0, 3) != 0;
            if (mem_req_valid && mem_req_ready) begin
                src = mem_req_tag[SRC_BIT]; kl = mem_req_tag[KL_BIT];
                if ((src ? bq.size() : fq.size()) == 0) begin
                    chk("rnd_beat_from_empty_src", 1, 0);
                end else begin
                    e = src ? bq[0] : fq[0];
                    chk("rnd_rn", mem_req_tag[TAG_W:1], e.rn);
                    if (!kl) begin
                        chk("rnd_k_while_l_pending", pend, 0);
                        chk("rnd_k_addr", mem_req_addr, e.k);
                        pend = 1; pend_src = src;
                    end else begin
                        chk("rnd_l_without_k", pend, 1);
                        chk("rnd_l_src", src, pend_src);
                        chk("rnd_l_addr", mem_req_addr, e.l);
                        if (src) void'(bq.pop_front()); else void'(fq.pop_front());
                        pend = 0;
                    end
                end
            end
            pv = mem_req_valid; pr = mem_req_ready; pa = mem_req_addr; pt = mem_req_tag;
            if (burst == 0) begin
                burst = $urandom_range(1, 4);
                cur_src = ~cur_src;
            end
            f_req_valid = 0; b_req_valid = 0;
            if (pushed < 40 && !f_stall && (cur_src == 0 || $urandom_range(0, 3) == 0)) begin
                e.k = ADDR_W'({$urandom(), $urandom()}); e.l = ADDR_W'({$urandom(), $urandom()}); e.rn = TAG_W'($urandom());
                f_req_valid = 1; f_addr_k = e.k; f_addr_l = e.l; f_read_num = e.rn;
                fq.push_back(e); pushed++;
                if (cur_src == 0) burst--;
            end
            if (pushed < 40 && !b_stall && (cur_src == 1 || $urandom_range(0, 3) == 0)) begin
                e.k = ADDR_W'({$urandom(), $urandom()}); e.l = ADDR_W'({$urandom(), $urandom()}); e.rn = TAG_W'($urandom());
                b_req_valid = 1; b_addr_k = e.k; b_addr_l = e.l; b_read_num = e.rn;
                bq.push_back(e); pushed++;
                if (cur_src == 1) burst--;
            end
            step();
        end
        f_req_valid = 0; b_req_valid = 0;
        chk("rnd_f_drained", fq.size(), 0);
        chk("rnd_b_drained", bq.size(), 0);
        chk("rnd_no_ovf", ovf_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
